mmio_port_responder: RTL and testbench
======================================

# mmio_port_responder

Memory-mapped I/O responder on the processor's data bus, alongside the data memory. It decodes load/store accesses to a 32-byte I/O window and drives the 32-bit output port from the PortOut register. It also synchronizes the 8-bit input port, latches change and timer events as sticky status flags, and raises an interrupt request. Reads are combinational so a single-cycle load completes in the same cycle; all state updates on the rising clock edge.

## Interface
- BASE_ADDR, 32'h1001_0040 — window base; bits [4:0] must be zero.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Address  input  32  byte address from ALU result.
- WriteData  input  32  store data (ReadData2 of register file).
- MemWrite  input  1  store strobe for current instruction.
- MemRead  input  1  load strobe for current instruction.
- ReadData  output  32  load data; 0 when not hit or not MemRead.
- Hit  output  1  Address[31:5]==BASE_ADDR[31:5]; top level selects ReadData over data memory and suppresses memory write when 1.
- PortIn  input  8  asynchronous external input.
- PortOut  output  32  output port register.
- IRQ  output  1  registered interrupt request.

## Operation
- Register offsets (Address[4:0]); accesses with Address[1:0]!=0 are ignored (write) / read 0:
  - 0x00 OUT (RW): drives PortOut directly.
  - 0x04 IN (RO): {24'b0, sync2}.
  - 0x08 STATUS (RW1C): bit0 CHG, bit1 TEXP; other bits read 0.
  - 0x0C TCMP (RW): timer period; 0 disables the timer.
  - 0x10 TCNT (RO): current timer count.
  - 0x14 CTRL (RW): bit0 CHG_IE, bit1 TEXP_IE; other bits read 0.
  - 0x18, 0x1C: read 0, writes ignored.
- Write occurs on the clock edge when Hit & MemWrite & aligned. Writes to RO offsets are ignored.
- Input path: sync1 <= PortIn; sync2 <= sync1; prev <= sync2. CHG sets when sync2 != prev.
- Timer: if TCMP==0, TCNT is held at 0. Otherwise TCNT increments each cycle. When TCNT==TCMP-1, the next edge loads TCNT=0 and sets TEXP. The period is TCMP cycles.
- A write to TCMP loads the new value and clears TCNT to 0 on the same edge. TEXP is not set on that edge.
- STATUS write: each bit written 1 clears its flag. If a flag's set condition and its clear occur on the same edge, set wins (flag stays 1).
- IRQ <= (CHG & CHG_IE) | (TEXP & TEXP_IE), registered one cycle after the flag or enable.
- MemRead and MemWrite both high: the read returns pre-write contents; the write takes effect at the edge.

## Timing
- Reset values: PortOut=0, ReadData=0 (combinational), Hit follows Address, IRQ=0, sync1/sync2/prev=0, all registers 0.
- Reset asserted mid-operation clears everything immediately. No flag sets on the first edge after release unless sync2!=prev.
- Read latency is 0 cycles (combinational from registers and Address).
- Write latency: the new value is visible on the edge ending the store cycle.
- PortIn change sampled at edge n: IN reflects it after edge n+1, CHG=1 after edge n+2, IRQ=1 after edge n+3 (if enabled).
- TCNT wrap: with TCMP=N, TEXP sets every N cycles. TCNT never exceeds N-1. Lowering TCMP below the current TCNT is safe because the write clears TCNT.
- TCMP=1: TCNT stays 0 and TEXP sets every cycle.

## Test plan
- Reset then store 0xDEADBEEF to BASE+0x00 → PortOut=0xDEADBEEF after the edge; load BASE+0x00 returns 0xDEADBEEF; Hit=1; load of BASE+0x20 gives Hit=0, ReadData=0.
- PortIn 0x00→0xA5 at edge n → IN reads 0x000000A5 after n+1; STATUS=0x1 after n+2; with CTRL=0x1, IRQ=1 after n+3. Write STATUS=0x1 → CHG=0, IRQ=0 the following cycle.
- TCMP=5 → TCNT sequence 0,1,2,3,4,0; TEXP sets on the wrap edge; repeats every 5 cycles. Write TCMP=0 → TCNT held at 0, no further TEXP.
- Clearing TEXP (write STATUS=0x2) on the exact wrap edge → TEXP reads 1 afterward (set wins).
- Misaligned store to BASE+0x01 with 0xFFFFFFFF → PortOut unchanged. Store to IN offset → IN unchanged. Load of BASE+0x18 → 0.
- Assert reset while TCMP=3 and CHG=1 → all outputs and registers return to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: 32-byte register window with output port, synchronized
// input port, change/timer sticky flags and a registered interrupt request.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        IRQ
);

    localparam logic [2:0] OFS_OUT    = 3'd0;
    localparam logic [2:0] OFS_IN     = 3'd1;
    localparam logic [2:0] OFS_STATUS = 3'd2;
    localparam logic [2:0] OFS_TCMP   = 3'd3;
    localparam logic [2:0] OFS_TCNT   = 3'd4;
    localparam logic [2:0] OFS_CTRL   = 3'd5;

    logic [7:0]  sync1, sync2, prev;
    logic        chg, texp, chgIe, texpIe;
    logic [31:0] tcmp, tcnt;

    logic        aligned, wrEn;
    logic [2:0]  offset;
    logic        wrOut, wrStatus, wrTcmp, wrCtrl;
    logic        chgSet, timerWrap;

    assign Hit      = (Address[31:5] == BASE_ADDR[31:5]);
    assign aligned  = (Address[1:0] == 2'b00);
    assign offset   = Address[4:2];
    assign wrEn     = Hit && MemWrite && aligned;
    assign wrOut    = wrEn && (offset == OFS_OUT);
    assign wrStatus = wrEn && (offset == OFS_STATUS);
    assign wrTcmp   = wrEn && (offset == OFS_TCMP);
    assign wrCtrl   = wrEn && (offset == OFS_CTRL);

    assign chgSet    = (sync2 != prev);
    // A TCMP store restarts the count, so it never produces a wrap on that edge.
    assign timerWrap = !wrTcmp && (tcmp != 32'd0) && (tcnt == tcmp - 32'd1);

    always_comb begin
        ReadData = 32'd0;
        if (Hit && MemRead && aligned) begin
            case (offset)
                OFS_OUT:    ReadData = PortOut;
                OFS_IN:     ReadData = {24'd0, sync2};
                OFS_STATUS: ReadData = {30'd0, texp, chg};
                OFS_TCMP:   ReadData = tcmp;
                OFS_TCNT:   ReadData = tcnt;
                OFS_CTRL:   ReadData = {30'd0, texpIe, chgIe};
                default:    ReadData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PortOut <= 32'd0;
            chgIe   <= 1'b0;
            texpIe  <= 1'b0;
        end else begin
            if (wrOut)
                PortOut <= WriteData;
            if (wrCtrl) begin
                chgIe  <= WriteData[0];
                texpIe <= WriteData[1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 8'd0;
            sync2 <= 8'd0;
            prev  <= 8'd0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcmp <= 32'd0;
            tcnt <= 32'd0;
        end else if (wrTcmp) begin
            tcmp <= WriteData;
            tcnt <= 32'd0;
        end else if (tcmp == 32'd0 || timerWrap) begin
            tcnt <= 32'd0;
        end else begin
            tcnt <= tcnt + 32'd1;
        end
    end

    // Sticky flags: a same-edge set overrides a write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg  <= 1'b0;
            texp <= 1'b0;
            IRQ  <= 1'b0;
        end else begin
            chg  <= chgSet || (chg && !(wrStatus && WriteData[0]));
            texp <= timerWrap || (texp && !(wrStatus && WriteData[1]));
            IRQ  <= (chg && chgIe) || (texp && texpIe);
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder; all activity happens in the
// clock-low phase so the rising edge sees stable inputs.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, WriteData, ReadData, PortOut;
    logic        MemWrite, MemRead, Hit, IRQ;
    logic [7:0]  PortIn;

    int testsRun = 0;
    int testsFailed = 0;

    mmio_port_responder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
        .PortIn(PortIn), .PortOut(PortOut), .IRQ(IRQ)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // One store cycle: drive in the low phase, the rising edge commits, return at next negedge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        Address = addr;
        MemRead = 1'b1;
        #1;
        data    = ReadData;
        MemRead = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        reset = 1'b1; Address = 32'd0; WriteData = 32'd0;
        MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
        #25;
        checkOutput("resetPortOut", PortOut, 32'd0);
        checkOutput("resetIrq", {31'd0, IRQ}, 32'd0);
        readReg(BASE + 32'h0C, rd);
        checkOutput("resetTcmp", rd, 32'd0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        // Output register store, readback and window decode
        applyStimulus(BASE, 32'hDEADBEEF);
        checkOutput("portOutStore", PortOut, 32'hDEADBEEF);
        readReg(BASE, rd);
        checkOutput("outReadback", rd, 32'hDEADBEEF);
        checkOutput("hitInWindow", {31'd0, Hit}, 32'd1);
        readReg(BASE + 32'h20, rd);
        checkOutput("hitOutside", {31'd0, Hit}, 32'd0);
        checkOutput("readOutside", rd, 32'd0);
        Address = BASE; #1;
        checkOutput("readNoMemRead", ReadData, 32'd0);

        // Input synchronizer, change flag and interrupt
        applyStimulus(BASE + 32'h14, 32'h1);
        PortIn = 8'hA5;
        nextCycle();
        readReg(BASE + 32'h04, rd);
        checkOutput("inAfterN", rd, 32'h0);
        nextCycle();
        readReg(BASE + 32'h04, rd);
        checkOutput("inAfterN1", rd, 32'hA5);
        readReg(BASE + 32'h08, rd);
        checkOutput("statusAfterN1", rd, 32'h0);
        nextCycle();
        readReg(BASE + 32'h08, rd);
        checkOutput("statusAfterN2", rd, 32'h1);
        checkOutput("irqAfterN2", {31'd0, IRQ}, 32'd0);
        nextCycle();
        checkOutput("irqAfterN3", {31'd0, IRQ}, 32'd1);
        applyStimulus(BASE + 32'h08, 32'h1);
        readReg(BASE + 32'h08, rd);
        checkOutput("chgCleared", rd, 32'h0);
        nextCycle();
        checkOutput("irqCleared", {31'd0, IRQ}, 32'd0);

        // Timer with period 5
        applyStimulus(BASE + 32'h14, 32'h0);
        applyStimulus(BASE + 32'h0C, 32'd5);
        readReg(BASE + 32'h0C, rd);
        checkOutput("tcmpReadback", rd, 32'd5);
        readReg(BASE + 32'h10, rd);
        checkOutput("tcntStart", rd, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            nextCycle();
            readReg(BASE + 32'h10, rd);
            checkOutput($sformatf("tcntStep%0d", i), rd, (i == 5) ? 32'd0 : 32'(i));
            readReg(BASE + 32'h08, rd);
            checkOutput($sformatf("texpStep%0d", i), rd, (i == 5) ? 32'h2 : 32'h0);
        end
        applyStimulus(BASE + 32'h08, 32'h2);
        readReg(BASE + 32'h08, rd);
        checkOutput("texpCleared", rd, 32'h0);
        nextCycle();
        nextCycle();
        readReg(BASE + 32'h10, rd);
        checkOutput("tcntBeforeWrap", rd, 32'd3);
        nextCycle();
        applyStimulus(BASE + 32'h08, 32'h2);
        readReg(BASE + 32'h08, rd);
        checkOutput("setWinsOverClear", rd, 32'h2);
        readReg(BASE + 32'h10, rd);
        checkOutput("tcntWrapped", rd, 32'd0);

        // Disabling the timer
        applyStimulus(BASE + 32'h0C, 32'd0);
        applyStimulus(BASE + 32'h08, 32'h2);
        for (int i = 0; i < 7; i++) nextCycle();
        readReg(BASE + 32'h10, rd);
        checkOutput("tcntHeld", rd, 32'd0);
        readReg(BASE + 32'h08, rd);
        checkOutput("noTexpDisabled", rd, 32'h0);

        // Ignored accesses and register masks
        applyStimulus(BASE + 32'h01, 32'hFFFFFFFF);
        checkOutput("misalignedStore", PortOut, 32'hDEADBEEF);
        applyStimulus(BASE + 32'h04, 32'h12);
        readReg(BASE + 32'h04, rd);
        checkOutput("inReadOnly", rd, 32'hA5);
        readReg(BASE + 32'h18, rd);
        checkOutput("reservedRead", rd, 32'h0);
        readReg(BASE + 32'h02, rd);
        checkOutput("misalignedRead", rd, 32'h0);
        applyStimulus(BASE + 32'h14, 32'hFFFFFFFF);
        readReg(BASE + 32'h14, rd);
        checkOutput("ctrlMask", rd, 32'h3);

        // Simultaneous load and store returns the old contents
        Address = BASE; WriteData = 32'h11; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        checkOutput("readBeforeWrite", ReadData, 32'hDEADBEEF);
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b0;
        checkOutput("writeAfterBoth", PortOut, 32'h11);

        // Asynchronous reset mid-operation
        applyStimulus(BASE + 32'h0C, 32'd3);
        PortIn = 8'h5A;
        for (int i = 0; i < 4; i++) nextCycle();
        readReg(BASE + 32'h08, rd);
        checkOutput("chgBeforeReset", {31'd0, rd[0]}, 32'd1);
        checkOutput("irqBeforeReset", {31'd0, IRQ}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("asyncPortOut", PortOut, 32'd0);
        checkOutput("asyncIrq", {31'd0, IRQ}, 32'd0);
        readReg(BASE + 32'h08, rd);
        checkOutput("asyncStatus", rd, 32'd0);
        readReg(BASE + 32'h0C, rd);
        checkOutput("asyncTcmp", rd, 32'd0);
        readReg(BASE + 32'h04, rd);
        checkOutput("asyncIn", rd, 32'd0);
        readReg(BASE + 32'h14, rd);
        checkOutput("asyncCtrl", rd, 32'd0);
        readReg(BASE + 32'h10, rd);
        checkOutput("asyncTcnt", rd, 32'd0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
